// File: rtl/core_boot_if.sv
// Boot-vector request/response bundle between a per-core boot sequencer
// and the boot ROM / vector server.
//   master : sequencer side. It drives the request valid and id, and the response ready.
//   slave  : server side. It drives the request ready, and the response valid, address and error.
interface core_boot_if #(
    parameter int ADDR_W = 32
);
    logic              boot_req_valid;
    logic              boot_req_ready;
    logic [7:0]        boot_req_id;
    logic              boot_rsp_valid;
    logic              boot_rsp_ready;
    logic [ADDR_W-1:0] boot_rsp_addr;
    logic              boot_rsp_err;

    modport master (
        output boot_req_valid, boot_req_id, boot_rsp_ready,
        input  boot_req_ready, boot_rsp_valid, boot_rsp_addr, boot_rsp_err
    );

    modport slave (
        input  boot_req_valid, boot_req_id, boot_rsp_ready,
        output boot_req_ready, boot_rsp_valid, boot_rsp_addr, boot_rsp_err
    );
endinterface

// File: rtl/core_boot_seq.sv
// Per-core boot sequencer. It runs in the core's gated clock domain.
// After the per-core reset releases, it waits a settle delay and then fetches
// the boot vector. It then releases the core to run. While the core runs, the
// block enforces a heartbeat watchdog and services halt requests. Any error
// ends in an absorbing FAULT state, and only rst_n_in clears that state.
// Ports:
//   core_clk, rst_n_in : gated core clock and asynchronous active-low reset
//   i_core_rst_n       : synchronised per-core reset; low holds the block in IDLE
//   bus (master)       : boot vector request/response handshake
//   i_wdt_limit        : watchdog limit in cycles; 0 disables the watchdog
//   i_heartbeat        : liveness pulse from the core
//   i_halt_req         : level request to pause the core
//   o_core_run, o_core_pc_init, o_core_ready, o_state, o_fault, o_fault_code
module core_boot_seq #(
    parameter int CORE_ID    = 0,
    parameter int ADDR_W     = 32,
    parameter int WDT_W      = 16,
    parameter int BOOT_DELAY = 8
) (
    input  logic              core_clk,
    input  logic              rst_n_in,
    input  logic              i_core_rst_n,
    core_boot_if.master       bus,
    input  logic [WDT_W-1:0]  i_wdt_limit,
    input  logic              i_heartbeat,
    input  logic              i_halt_req,
    output logic              o_core_run,
    output logic [ADDR_W-1:0] o_core_pc_init,
    output logic              o_core_ready,
    output logic [2:0]        o_state,
    output logic              o_fault,
    output logic [1:0]        o_fault_code
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_REQ   = 3'd2,
        S_RSP   = 3'd3,
        S_RUN   = 3'd4,
        S_HALT  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    localparam int DELAY_CYC = (BOOT_DELAY < 1) ? 1 : BOOT_DELAY;
    localparam int DLY_W     = $clog2(DELAY_CYC + 1);
    // A single counter serves both the settle delay and the watchdog.
    localparam int CNT_W     = (WDT_W > DLY_W) ? WDT_W : DLY_W;

    // The counter saturates and never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1'b1);
    endfunction

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req_valid;
    logic              r_rsp_ready;
    logic [7:0]        r_req_id;
    logic              r_run;
    logic              r_ready;
    logic [ADDR_W-1:0] r_pc;
    logic              r_fault;
    logic [1:0]        r_code;

    logic [CNT_W-1:0]  w_limit_m1;
    logic              w_wdt_hit;
    logic              w_dly_done;
    logic              w_misaligned;

    // Expiry fires on the edge where the counter reaches limit-1. The fault
    // is therefore entered on the limit-th edge after the counter cleared.
    assign w_limit_m1   = CNT_W'(i_wdt_limit) - CNT_W'(1'b1);
    assign w_wdt_hit    = (i_wdt_limit != {WDT_W{1'b0}}) && (r_cnt == w_limit_m1);
    // The DELAY state spans DELAY_CYC+1 edges. The request therefore rises
    // 1+DELAY_CYC edges after reset release is first sampled.
    assign w_dly_done   = (r_cnt == CNT_W'(DELAY_CYC));
    assign w_misaligned = (bus.boot_rsp_addr[1:0] != 2'b00);

    // Sequencer FSM: next state, counter and every registered output
    always_ff @(posedge core_clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req_valid <= 1'b0;
            r_rsp_ready <= 1'b0;
            r_req_id    <= 8'(CORE_ID);
            r_run       <= 1'b0;
            r_ready     <= 1'b0;
            r_pc        <= '0;
            r_fault     <= 1'b0;
            r_code      <= 2'd0;
        end else if ((r_state != S_FAULT) && !i_core_rst_n) begin
            // The boot address is kept across a per-core reset.
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req_valid <= 1'b0;
            r_rsp_ready <= 1'b0;
            r_run       <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_DELAY;
                    r_cnt   <= '0;
                end
                S_DELAY: begin
                    if (w_dly_done) begin
                        r_state     <= S_REQ;
                        r_req_valid <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                S_REQ: begin
                    if (r_req_valid && bus.boot_req_ready) begin
                        r_state     <= S_RSP;
                        r_req_valid <= 1'b0;
                        r_rsp_ready <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_req_valid <= 1'b1;
                    end
                end
                S_RSP: begin
                    // A valid response beats the response timeout in the same cycle.
                    if (bus.boot_rsp_valid) begin
                        r_rsp_ready <= 1'b0;
                        r_cnt       <= '0;
                        if (bus.boot_rsp_err) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                            r_code  <= 2'd1;
                        end else if (w_misaligned) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                            r_code  <= 2'd2;
                        end else begin
                            r_state <= S_RUN;
                            r_pc    <= bus.boot_rsp_addr;
                            r_run   <= 1'b1;
                            r_ready <= 1'b1;
                        end
                    end else if (w_wdt_hit) begin
                        r_state     <= S_FAULT;
                        r_rsp_ready <= 1'b0;
                        r_fault     <= 1'b1;
                        r_code      <= 2'd3;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                S_RUN: begin
                    // A halt or a heartbeat in the same cycle beats watchdog expiry.
                    if (i_halt_req) begin
                        r_state <= S_HALT;
                        r_run   <= 1'b0;
                        r_ready <= 1'b0;
                    end else if (i_heartbeat) begin
                        r_cnt <= '0;
                    end else if (w_wdt_hit) begin
                        r_state <= S_FAULT;
                        r_run   <= 1'b0;
                        r_ready <= 1'b0;
                        r_fault <= 1'b1;
                        r_code  <= 2'd3;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                S_HALT: begin
                    if (!i_halt_req) begin
                        r_state <= S_RUN;
                        r_run   <= 1'b1;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_run <= 1'b0;
                    end
                end
                S_FAULT: begin
                    r_run   <= 1'b0;
                    r_fault <= 1'b1;
                end
                default: begin
                    // An unreachable encoding recovers to a quiet IDLE state.
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_req_valid <= 1'b0;
                    r_rsp_ready <= 1'b0;
                    r_run       <= 1'b0;
                    r_ready     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.boot_req_valid = r_req_valid;
    assign bus.boot_rsp_ready = r_rsp_ready;
    assign bus.boot_req_id    = r_req_id;
    assign o_core_run         = r_run;
    assign o_core_pc_init     = r_pc;
    assign o_core_ready       = r_ready;
    assign o_state            = r_state;
    assign o_fault            = r_fault;
    assign o_fault_code       = r_code;
endmodule

// File: tb/tb_core_boot_seq.sv
// Self-checking bench for core_boot_seq. It runs directed scenarios for each
// boot, fault, watchdog, halt and reset case, followed by randomized traffic.
// Every cycle, all outputs are compared against a phase-level reference model.
module tb_core_boot_seq;
    localparam int CORE_ID    = 5;
    localparam int ADDR_W     = 32;
    localparam int WDT_W      = 16;
    localparam int BOOT_DELAY = 8;
    localparam int D          = (BOOT_DELAY < 1) ? 1 : BOOT_DELAY;

    logic              core_clk   = 1'b0;
    logic              rst_n_in   = 1'b1;
    logic              core_rst_n = 1'b0;
    logic [WDT_W-1:0]  wdt_limit  = '0;
    logic              heartbeat  = 1'b0;
    logic              halt_req   = 1'b0;
    logic              core_run;
    logic [ADDR_W-1:0] core_pc_init;
    logic              core_ready;
    logic [2:0]        state;
    logic              fault;
    logic [1:0]        fault_code;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model. The phase uses the published state codes. m_el counts
    // the edges since the phase was entered, or since the last heartbeat.
    int                m_st;
    int                m_el;
    int                m_code;
    logic [ADDR_W-1:0] m_pc;

    int          n;
    int          hb_div;
    logic [31:0] a;

    core_boot_if #(.ADDR_W(ADDR_W)) bus ();

    core_boot_seq #(
        .CORE_ID(CORE_ID), .ADDR_W(ADDR_W), .WDT_W(WDT_W), .BOOT_DELAY(BOOT_DELAY)
    ) dut (
        .core_clk      (core_clk),
        .rst_n_in      (rst_n_in),
        .i_core_rst_n  (core_rst_n),
        .bus           (bus),
        .i_wdt_limit   (wdt_limit),
        .i_heartbeat   (heartbeat),
        .i_halt_req    (halt_req),
        .o_core_run    (core_run),
        .o_core_pc_init(core_pc_init),
        .o_core_ready  (core_ready),
        .o_state       (state),
        .o_fault       (fault),
        .o_fault_code  (fault_code)
    );

    always #5 core_clk = ~core_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_el = 0; m_code = 0; m_pc = '0;
    endtask

    task automatic model_fault(input int c);
        m_st = 6; m_code = c;
    endtask

    // The model is advanced by one clock edge, using the inputs the DUT sampled.
    task automatic model_step();
        if (!rst_n_in) begin
            model_reset();
        end else if (m_st != 6 && !core_rst_n) begin
            m_st = 0; m_el = 0;
        end else begin
            case (m_st)
                0: begin m_st = 1; m_el = 0; end
                1: begin
                    m_el++;
                    if (m_el == D + 1) begin m_st = 2; m_el = 0; end
                end
                2: if (bus.boot_req_ready) begin m_st = 3; m_el = 0; end
                3: begin
                    if (bus.boot_rsp_valid) begin
                        if (bus.boot_rsp_err) model_fault(1);
                        else if (bus.boot_rsp_addr[1:0] != 2'b00) model_fault(2);
                        else begin m_pc = bus.boot_rsp_addr; m_st = 4; m_el = 0; end
                    end else begin
                        m_el++;
                        if (wdt_limit != 0 && m_el == int'(wdt_limit)) model_fault(3);
                    end
                end
                4: begin
                    if (halt_req) m_st = 5;
                    else if (heartbeat) m_el = 0;
                    else begin
                        m_el++;
                        if (wdt_limit != 0 && m_el == int'(wdt_limit)) model_fault(3);
                    end
                end
                5: if (!halt_req) begin m_st = 4; m_el = 0; end
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        chk("state",       state,              m_st);
        chk("req_valid",   bus.boot_req_valid, m_st == 2);
        chk("rsp_ready",   bus.boot_rsp_ready, m_st == 3);
        chk("core_run",    core_run,           m_st == 4);
        chk("core_ready",  core_ready,         m_st == 4);
        chk("pc_init",     core_pc_init,       m_pc);
        chk("fault",       fault,              m_st == 6);
        chk("fault_code",  fault_code,         m_code);
        chk("req_id",      bus.boot_req_id,    CORE_ID);
    endtask

    task automatic cycle();
        @(posedge core_clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0; core_rst_n = 1'b0; heartbeat = 1'b0; halt_req = 1'b0;
        bus.boot_req_ready = 1'b0; bus.boot_rsp_valid = 1'b0;
        bus.boot_rsp_err = 1'b0; bus.boot_rsp_addr = '0;
        #1;
        model_reset();
        check_all();
        cycle();
        cycle();
        rst_n_in = 1'b1;
    endtask

    // This task releases the core reset. It then counts the edges after the
    // first sampled-high edge until the request rises, and the count is bounded.
    task automatic release_and_count(output int cnt);
        core_rst_n = 1'b1;
        cycle();
        cnt = 0;
        while (!bus.boot_req_valid && cnt < 50) begin
            cycle();
            cnt++;
        end
    endtask

    task automatic grant();
        bus.boot_req_ready = 1'b1;
        cycle();
        bus.boot_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [ADDR_W-1:0] addr, input logic err);
        bus.boot_rsp_valid = 1'b1; bus.boot_rsp_addr = addr; bus.boot_rsp_err = err;
        cycle();
        bus.boot_rsp_valid = 1'b0; bus.boot_rsp_err = 1'b0;
    endtask

    task automatic toggle_core_rst();
        core_rst_n = 1'b0; cycle(); cycle();
        core_rst_n = 1'b1; cycle();
    endtask

    initial begin
        bus.boot_req_ready = 1'b0; bus.boot_rsp_valid = 1'b0;
        bus.boot_rsp_err = 1'b0; bus.boot_rsp_addr = '0;
        #2;
        do_reset();
        chk("rst_state", state, 64'd0);
        chk("rst_req_id", bus.boot_req_id, CORE_ID);

        // Nominal boot
        wdt_limit = '0;
        release_and_count(n);
        chk("boot_latency", n, D + 1);
        grant();
        chk("req_valid_after_grant", bus.boot_req_valid, 1'b0);
        chk("rsp_ready_after_grant", bus.boot_rsp_ready, 1'b1);
        respond(32'h0000_1000, 1'b0);
        chk("run_after_rsp", core_run, 1'b1);
        chk("pc_after_rsp", core_pc_init, 64'h1000);
        chk("no_fault_after_rsp", fault, 1'b0);

        // Watchdog: heartbeats keep RUN, a heartbeat on the expiry edge saves it
        wdt_limit = 16'd4;
        for (int i = 0; i < 50; i++) begin
            heartbeat = (i % 3 == 0);
            cycle();
        end
        heartbeat = 1'b0;
        chk("hb_keeps_run", state, 64'd4);
        cycle(); cycle();
        heartbeat = 1'b1; cycle(); heartbeat = 1'b0;
        chk("hb_on_expiry", state, 64'd4);
        for (int k = 1; k <= 4; k++) begin
            cycle();
            if (k < 4) chk("wdt_before_expiry", state, 64'd4);
        end
        chk("wdt_fault_state", state, 64'd6);
        chk("wdt_fault_code", fault_code, 64'd3);
        chk("wdt_run_low", core_run, 1'b0);
        toggle_core_rst();
        chk("fault_ignores_core_rst", state, 64'd6);
        do_reset();
        chk("rst_clears_fault", fault, 1'b0);
        chk("rst_clears_code", fault_code, 64'd0);
        chk("rst_clears_pc", core_pc_init, 64'd0);

        // Halt with a short watchdog and no heartbeat
        wdt_limit = 16'd2;
        release_and_count(n);
        grant();
        respond(32'h0000_2000, 1'b0);
        halt_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("halt_run_low", core_run, 1'b0);
            chk("halt_no_fault", fault, 1'b0);
        end
        halt_req = 1'b0;
        cycle();
        chk("resume_run", core_run, 1'b1);
        cycle();
        chk("resume_fresh_cnt", state, 64'd4);
        cycle();
        chk("resume_wdt_expiry", state, 64'd6);

        // Response error and misaligned address
        do_reset();
        wdt_limit = '0;
        release_and_count(n);
        grant();
        respond(32'h0000_1000, 1'b1);
        chk("err_state", state, 64'd6);
        chk("err_code", fault_code, 64'd1);
        chk("err_run_low", core_run, 1'b0);
        toggle_core_rst();
        chk("err_sticky", state, 64'd6);
        do_reset();
        release_and_count(n);
        grant();
        respond(32'h0000_1002, 1'b0);
        chk("misalign_code", fault_code, 64'd2);
        chk("misalign_run_low", core_run, 1'b0);
        toggle_core_rst();
        chk("misalign_sticky", state, 64'd6);

        // Core reset during REQ, then full DELAY again and response timeout
        do_reset();
        release_and_count(n);
        cycle(); cycle();
        core_rst_n = 1'b0;
        cycle();
        chk("midreq_valid_low", bus.boot_req_valid, 1'b0);
        chk("midreq_idle", state, 64'd0);
        release_and_count(n);
        chk("rerelease_latency", n, D + 1);
        wdt_limit = 16'd5;
        grant();
        for (int k = 1; k <= 5; k++) begin
            cycle();
            if (k < 5) chk("rsp_wait", state, 64'd3);
        end
        chk("rsp_timeout_code", fault_code, 64'd3);
        do_reset();
        wdt_limit = 16'd5;
        release_and_count(n);
        grant();
        for (int k = 1; k <= 4; k++) cycle();
        respond(32'h0000_4000, 1'b0);
        chk("rsp_beats_timeout", state, 64'd4);

        // Randomized traffic against the model
        for (int r = 0; r < 30; r++) begin
            do_reset();
            wdt_limit = ($urandom_range(0, 3) == 0) ? 16'd0 : WDT_W'($urandom_range(2, 12));
            hb_div = $urandom_range(1, 14);
            for (int c = 0; c < 250; c++) begin
                core_rst_n         = ($urandom_range(0, 79) != 0);
                bus.boot_req_ready = ($urandom_range(0, 2) == 0);
                bus.boot_rsp_valid = ($urandom_range(0, 5) == 0);
                bus.boot_rsp_err   = ($urandom_range(0, 15) == 0);
                a = $urandom();
                if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
                bus.boot_rsp_addr  = a;
                heartbeat          = ($urandom_range(1, hb_div) == 1);
                if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
